// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES f-function tables, tag width and permutation helpers
package des_pkg;

    localparam int TAG_W = 4;

    // DES bit numbers (1 = MSB) selected for each expanded output bit, output bit 1 first.
    localparam logic [5:0] E_TABLE [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    // DES bit numbers of the S-box output feeding each f output bit, output bit 1 first.
    localparam logic [5:0] P_TABLE [32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[6'(47 - i)] = r[5'(6'd32 - E_TABLE[i])];
        end
        return e;
    endfunction

    function automatic logic [31:0] p_permute(input logic [31:0] s);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            p[5'(31 - i)] = s[5'(6'd32 - P_TABLE[i])];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_sbox_bank.sv
// rtl/des_sbox_bank.sv - combinational bank of the eight S-boxes, S1 in the MSBs
module des_sbox_bank (
    input  logic [47:0] x,
    output logic [31:0] s
);
    sbox1_lut u_s1 (.addr(x[47:42]), .data(s[31:28]));
    sbox2_lut u_s2 (.addr(x[41:36]), .data(s[27:24]));
    sbox3_lut u_s3 (.addr(x[35:30]), .data(s[23:20]));
    sbox4_lut u_s4 (.addr(x[29:24]), .data(s[19:16]));
    sbox5_lut u_s5 (.addr(x[23:18]), .data(s[15:12]));
    sbox6_lut u_s6 (.addr(x[17:12]), .data(s[11:8]));
    sbox7_lut u_s7 (.addr(x[11:6]),  .data(s[7:4]));
    sbox8_lut u_s8 (.addr(x[5:0]),   .data(s[3:0]));
endmodule

// File: rtl/des_sbox_luts.sv
// rtl/des_sbox_luts.sv - the eight DES S-box lookup tables
// Each table holds 64 nibbles, row-major (row = {b1,b6}, column = b2..b5), entry 0 in the MSBs.
module sbox1_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox2_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox3_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox4_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox5_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox6_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox7_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox8_lut (input logic [5:0] addr, output logic [3:0] data);
    localparam logic [255:0] TABLE = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    logic [5:0] idx;
    assign idx  = {addr[5], addr[0], addr[4:1]};
    assign data = TABLE[{~idx, 2'b11} -: 4];
endmodule

// File: rtl/des_feistel_f.sv
// rtl/des_feistel_f.sv - two-stage pipelined DES round function f(R,K) with valid/ready flow control
module des_feistel_f
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      r_in,
    input  logic [47:0]      subkey,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      f_out,
    output logic [TAG_W-1:0] tag_out
);

    logic             s1_valid;
    logic [47:0]      s1_x;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s_box;
    logic             s2_load;
    logic             s1_load;

    // A stage advances when it is empty or its contents move downstream this cycle.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    des_sbox_bank u_sbox_bank (
        .x (s1_x),
        .s (s_box)
    );

    // Stage 1: capture E(R) xor K and the tag; data is only rewritten on a real input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x   <= e_expand(r_in) ^ subkey;
                s1_tag <= tag_in;
            end
        end
    end

    // Stage 2: S-box substitution plus P permutation into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f_out     <= '0;
            tag_out   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f_out   <= p_permute(s_box);
                tag_out <= s1_tag;
            end
        end
    end

endmodule
